// File: rtl/uart_fifo_transceiver.sv
`default_nettype none
// ============================================================================
// Module : uart_fifo_transceiver
// Brief  : Parametrised full-duplex UART with TX/RX FIFOs and sticky errors.
// Rev    : 1.0
// ============================================================================
module uart_fifo_transceiver #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 434,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    output logic                 tx_busy,
    input  logic                 uart_rx,
    output logic                 uart_tx
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_TW = $clog2(STOP_BITS * CLK_DIV);
    localparam int c_RW = $clog2(CLK_DIV);
    localparam int c_IW = $clog2(DATA_BITS);

    localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_TW-1:0] c_TBIT_LD  = c_TW'(CLK_DIV - 1);
    localparam logic [c_TW-1:0] c_TSTOP_LD = c_TW'(STOP_BITS * CLK_DIV - 1);
    localparam logic [c_RW-1:0] c_RBIT_LD  = c_RW'(CLK_DIV - 1);
    localparam logic [c_RW-1:0] c_RHALF_LD = c_RW'(CLK_DIV / 2 - 1);
    localparam logic [c_IW-1:0] c_LAST     = c_IW'(DATA_BITS - 1);
    localparam logic            c_PAR      = (PARITY_EN != 0);
    localparam logic            c_ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------ TX FIFO
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_tx_wr, r_tx_rd;
    logic [c_AW:0]        r_tx_cnt;
    logic                 w_tx_push, w_tx_pop, w_tx_nempty;

    assign tx_ready    = (r_tx_cnt != c_FULL);
    assign w_tx_push   = tx_valid & tx_ready;
    assign w_tx_nempty = (r_tx_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_data;
    end

    // ------------------------------------------------------------------ TX FSM
    state_t               r_tx_state, w_tx_state_n;
    logic [c_TW-1:0]      r_tx_tmr, w_tx_tmr_n;
    logic [c_IW-1:0]      r_tx_idx, w_tx_idx_n;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
    logic                 r_tx_par, w_tx_par_n;
    logic                 r_tx_line, w_tx_line_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= S_IDLE;
            r_tx_tmr   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_tmr   <= w_tx_tmr_n;
            r_tx_idx   <= w_tx_idx_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_par   <= w_tx_par_n;
            r_tx_line  <= w_tx_line_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_tmr_n   = r_tx_tmr - 1'b1;
        w_tx_idx_n   = r_tx_idx;
        w_tx_shift_n = r_tx_shift;
        w_tx_par_n   = r_tx_par;
        w_tx_line_n  = r_tx_line;
        w_tx_pop     = 1'b0;
        case (r_tx_state)
            S_IDLE, S_STOP: begin
                // The end of STOP chains straight into the next START.
                if (r_tx_state == S_IDLE || r_tx_tmr == '0) begin
                    if (w_tx_nempty) begin
                        w_tx_pop     = 1'b1;
                        w_tx_state_n = S_START;
                        w_tx_tmr_n   = c_TBIT_LD;
                        w_tx_shift_n = r_tx_mem[r_tx_rd];
                        w_tx_par_n   = (^r_tx_mem[r_tx_rd]) ^ c_ODD;
                        w_tx_line_n  = 1'b0;
                    end else begin
                        w_tx_state_n = S_IDLE;
                        w_tx_tmr_n   = '0;
                        w_tx_line_n  = 1'b1;
                    end
                end
            end
            S_START: begin
                if (r_tx_tmr == '0) begin
                    w_tx_state_n = S_DATA;
                    w_tx_tmr_n   = c_TBIT_LD;
                    w_tx_idx_n   = '0;
                    w_tx_line_n  = r_tx_shift[0];
                end
            end
            S_DATA: begin
                if (r_tx_tmr == '0) begin
                    w_tx_tmr_n = c_TBIT_LD;
                    if (r_tx_idx != c_LAST) begin
                        w_tx_idx_n   = r_tx_idx + 1'b1;
                        w_tx_shift_n = r_tx_shift >> 1;
                        w_tx_line_n  = r_tx_shift[1];
                    end else if (c_PAR) begin
                        w_tx_state_n = S_PARITY;
                        w_tx_line_n  = r_tx_par;
                    end else begin
                        w_tx_state_n = S_STOP;
                        w_tx_tmr_n   = c_TSTOP_LD;
                        w_tx_line_n  = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (r_tx_tmr == '0) begin
                    w_tx_state_n = S_STOP;
                    w_tx_tmr_n   = c_TSTOP_LD;
                    w_tx_line_n  = 1'b1;
                end
            end
            default: begin
                w_tx_state_n = S_IDLE;
                w_tx_line_n  = 1'b1;
            end
        endcase
    end

    assign uart_tx = r_tx_line;
    assign tx_busy = w_tx_nempty | (r_tx_state != S_IDLE);

    // ------------------------------------------------------------------ RX FSM
    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    logic                 w_rx_s;
    state_t               r_rx_state, w_rx_state_n;
    logic [c_RW-1:0]      r_rx_tmr, w_rx_tmr_n;
    logic [c_IW-1:0]      r_rx_idx, w_rx_idx_n;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_n;
    logic                 r_rx_par, w_rx_par_n;
    logic                 w_rx_done;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_tmr   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], uart_rx};
            r_rx_prev  <= w_rx_s;
            r_rx_state <= w_rx_state_n;
            r_rx_tmr   <= w_rx_tmr_n;
            r_rx_idx   <= w_rx_idx_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_par   <= w_rx_par_n;
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_tmr_n   = r_rx_tmr - 1'b1;
        w_rx_idx_n   = r_rx_idx;
        w_rx_shift_n = r_rx_shift;
        w_rx_par_n   = r_rx_par;
        w_rx_done    = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_tmr_n = '0;
                if (r_rx_prev && !w_rx_s) begin
                    w_rx_state_n = S_START;
                    w_rx_tmr_n   = c_RHALF_LD;
                end
            end
            S_START: begin
                if (r_rx_tmr == '0) begin
                    w_rx_state_n = w_rx_s ? S_IDLE : S_DATA;
                    w_rx_tmr_n   = c_RBIT_LD;
                    w_rx_idx_n   = '0;
                end
            end
            S_DATA: begin
                if (r_rx_tmr == '0) begin
                    w_rx_tmr_n   = c_RBIT_LD;
                    w_rx_shift_n = {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
                    w_rx_idx_n   = r_rx_idx + 1'b1;
                    if (r_rx_idx == c_LAST) w_rx_state_n = c_PAR ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (r_rx_tmr == '0) begin
                    w_rx_par_n   = w_rx_s;
                    w_rx_state_n = S_STOP;
                    w_rx_tmr_n   = c_RBIT_LD;
                end
            end
            S_STOP: begin
                if (r_rx_tmr == '0) begin
                    w_rx_done    = 1'b1;
                    w_rx_state_n = S_IDLE;
                end
            end
            default: w_rx_state_n = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ RX FIFO
    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_rx_wr, r_rx_rd;
    logic [c_AW:0]        r_rx_cnt;
    logic                 w_bad_stop, w_bad_par, w_rx_good;
    logic                 w_rx_push, w_rx_pop, w_overrun;

    assign w_bad_stop = w_rx_done & ~w_rx_s;
    assign w_bad_par  = w_rx_done & c_PAR & (r_rx_par != ((^r_rx_shift) ^ c_ODD));
    assign w_rx_good  = w_rx_done & ~w_bad_stop & ~w_bad_par;
    assign w_rx_pop   = rx_valid & rx_ready;
    // A pop in the completion cycle frees the slot for the incoming byte.
    assign w_rx_push  = w_rx_good & ((r_rx_cnt != c_FULL) | w_rx_pop);
    assign w_overrun  = w_rx_good & ~w_rx_push;

    assign rx_valid = (r_rx_cnt != '0);
    assign rx_data  = r_rx_mem[r_rx_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wr] <= r_rx_shift;
                r_rx_wr           <= r_rx_wr + 1'b1;
            end
            if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------ Errors
    logic r_err_frame, r_err_parity, r_err_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_frame   <= 1'b0;
            r_err_parity  <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_frame   <= w_bad_stop | (r_err_frame   & ~err_clr);
            r_err_parity  <= w_bad_par  | (r_err_parity  & ~err_clr);
            r_err_overrun <= w_overrun  | (r_err_overrun & ~err_clr);
        end
    end

    assign err_frame   = r_err_frame;
    assign err_parity  = r_err_parity;
    assign err_overrun = r_err_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_transceiver.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_fifo_transceiver
// Brief  : Scoreboarded bench for three UART configurations (8N1, 8E1, 7O2).
// Rev    : 1.0
// ============================================================================
module tb_uart_fifo_transceiver;

    localparam int CD  = 8;
    localparam int CDC = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // dut_a: 8N1, RX driven by the bench
    logic [7:0] tx_data_a, rx_data_a;
    logic tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, err_clr_a;
    logic err_frame_a, err_parity_a, err_overrun_a, tx_busy_a, uart_tx_a, drv_a;
    // dut_b: 8E1, RX either looped back or driven by the bench
    logic [7:0] tx_data_b, rx_data_b;
    logic tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, err_clr_b;
    logic err_frame_b, err_parity_b, err_overrun_b, tx_busy_b, uart_tx_b, drv_b, loop_b;
    // dut_c: 7O2, permanent loopback
    logic [6:0] tx_data_c, rx_data_c;
    logic tx_valid_c, tx_ready_c, rx_valid_c, rx_ready_c, err_clr_c;
    logic err_frame_c, err_parity_c, err_overrun_c, tx_busy_c, uart_tx_c;

    uart_fifo_transceiver #(.DATA_BITS(8), .CLK_DIV(CD), .PARITY_EN(0), .PARITY_ODD(0),
                            .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .err_clr(err_clr_a), .err_frame(err_frame_a),
        .err_parity(err_parity_a), .err_overrun(err_overrun_a), .tx_busy(tx_busy_a),
        .uart_rx(drv_a), .uart_tx(uart_tx_a));

    uart_fifo_transceiver #(.DATA_BITS(8), .CLK_DIV(CD), .PARITY_EN(1), .PARITY_ODD(0),
                            .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .err_clr(err_clr_b), .err_frame(err_frame_b),
        .err_parity(err_parity_b), .err_overrun(err_overrun_b), .tx_busy(tx_busy_b),
        .uart_rx(loop_b ? uart_tx_b : drv_b), .uart_tx(uart_tx_b));

    uart_fifo_transceiver #(.DATA_BITS(7), .CLK_DIV(CDC), .PARITY_EN(1), .PARITY_ODD(1),
                            .STOP_BITS(2), .FIFO_DEPTH(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_c), .tx_valid(tx_valid_c),
        .tx_ready(tx_ready_c), .rx_data(rx_data_c), .rx_valid(rx_valid_c),
        .rx_ready(rx_ready_c), .err_clr(err_clr_c), .err_frame(err_frame_c),
        .err_parity(err_parity_c), .err_overrun(err_overrun_c), .tx_busy(tx_busy_c),
        .uart_rx(uart_tx_c), .uart_tx(uart_tx_c));

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [6:0] exp_c[$];
    logic       exp_bits[$];
    logic [7:0] burst[$];
    int         pops_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare every byte the DUT hands over.
    always @(negedge clk) begin
        if (rst_n && rx_valid_a && rx_ready_a) begin
            pops_a++;
            if (exp_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_a unexpected byte: got %0h expected none", rx_data_a);
            end else chk("rx_a data", rx_data_a, exp_a.pop_front());
        end
    end
    always @(negedge clk) begin
        if (rst_n && rx_valid_b && rx_ready_b) begin
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_b unexpected byte: got %0h expected none", rx_data_b);
            end else chk("rx_b data", rx_data_b, exp_b.pop_front());
        end
    end
    always @(negedge clk) begin
        if (rst_n && rx_valid_c && rx_ready_c) begin
            if (exp_c.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_c unexpected byte: got %0h expected none", rx_data_c);
            end else chk("rx_c data", rx_data_c, exp_c.pop_front());
        end
    end

    // Reference serial frame: start, data LSB first, optional parity, stop bits.
    task automatic frame_bits(input logic [7:0] d, input int nb, input bit pen,
                              input bit podd, input int nstop);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) exp_bits.push_back(d[i]);
        if (pen) exp_bits.push_back((($countones(d) % 2) != 0) ^ podd);
        for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
    endtask

    // Push burst[] on consecutive cycles into dut_a (sel 0) or dut_b (sel 1)
    // and check uart_tx cycle by cycle against the reference frames.
    task automatic tx_stream(input int sel);
        int   total;
        logic line, busy;
        exp_bits.delete();
        foreach (burst[i]) frame_bits(burst[i], 8, sel == 1, 1'b0, 1);
        total = exp_bits.size() * CD;
        for (int t = 0; t <= total + 2; t++) begin
            if (sel == 0) begin
                tx_valid_a = (t < burst.size());
                tx_data_a  = (t < burst.size()) ? burst[t] : 8'h00;
            end else begin
                tx_valid_b = (t < burst.size());
                tx_data_b  = (t < burst.size()) ? burst[t] : 8'h00;
            end
            @(negedge clk);
            line = (sel == 0) ? uart_tx_a : uart_tx_b;
            busy = (sel == 0) ? tx_busy_a : tx_busy_b;
            if (t == 1) chk("tx idle before start bit", line, 1);
            else if (t >= 2 && t < total + 2) begin
                chk($sformatf("tx bit-cycle %0d", t - 2), line, exp_bits[(t - 2) / CD]);
                chk("tx_busy during frame", busy, 1);
            end else if (t == total + 2) begin
                chk("tx_busy after last stop", busy, 0);
                chk("tx idle after frames", line, 1);
            end
            @(posedge clk); #1;
        end
    endtask

    // Drive one raw frame onto dut_a (sel 0) or dut_b (sel 1) uart_rx.
    task automatic drive_frame(input int sel, input logic [7:0] d, input bit has_par,
                               input bit par, input bit stop);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (has_par) bits.push_back(par);
        bits.push_back(stop);
        foreach (bits[i]) begin
            if (sel == 0) drv_a = bits[i]; else drv_b = bits[i];
            repeat (CD) @(posedge clk);
            #1;
        end
        if (sel == 0) drv_a = 1'b1; else drv_b = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         p0;
        rst_n = 1'b0;
        tx_data_a = '0; tx_valid_a = 0; rx_ready_a = 1; err_clr_a = 0; drv_a = 1;
        tx_data_b = '0; tx_valid_b = 0; rx_ready_b = 1; err_clr_b = 0; drv_b = 1; loop_b = 0;
        tx_data_c = '0; tx_valid_c = 0; rx_ready_c = 1; err_clr_c = 0;
        cycles(3);
        @(negedge clk);
        chk("reset uart_tx", uart_tx_a, 1);
        chk("reset tx_ready", tx_ready_a, 1);
        chk("reset rx_valid", rx_valid_a, 0);
        chk("reset rx_data", rx_data_a, 0);
        chk("reset tx_busy", tx_busy_a, 0);
        chk("reset errors a", {err_frame_a, err_parity_a, err_overrun_a}, 0);
        chk("reset errors b", {err_frame_b, err_parity_b, err_overrun_b}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cycles(2);

        // Serial pattern 0xA5 on 8N1
        burst = '{8'hA5};
        tx_stream(0);

        // False start followed by a good frame
        drv_a = 1'b0;
        cycles(2);
        drv_a = 1'b1;
        cycles(20);
        @(negedge clk);
        chk("false start rx_valid", rx_valid_a, 0);
        chk("false start errors", {err_frame_a, err_parity_a, err_overrun_a}, 0);
        @(posedge clk); #1;
        exp_a.push_back(8'h5A);
        drive_frame(0, 8'h5A, 0, 0, 1);
        cycles(3);
        chk("after false start frame received", exp_a.size(), 0);

        // Frame error: bad stop bit, byte discarded
        drive_frame(0, 8'h33, 0, 0, 0);
        cycles(4);
        @(negedge clk);
        chk("frame error flag", err_frame_a, 1);
        chk("frame error rx_valid", rx_valid_a, 0);
        @(posedge clk); #1 err_clr_a = 1;
        @(posedge clk); #1 err_clr_a = 0;
        @(negedge clk);
        chk("err_clr frame", err_frame_a, 0);
        @(posedge clk); #1;

        // Overrun: four stored, fifth dropped
        rx_ready_a = 0;
        p0 = pops_a;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            if (i < 4) exp_a.push_back(d);
            drive_frame(0, d, 0, 0, 1);
            cycles(2);
            if (i == 3) chk("no overrun at four", err_overrun_a, 0);
        end
        chk("overrun flag", err_overrun_a, 1);
        chk("overrun no frame err", err_frame_a, 0);
        err_clr_a = 1;
        cycles(1);
        err_clr_a = 0;
        // Sixth frame completes in the same cycle as a pop
        d = 8'($urandom);
        exp_a.push_back(d);
        fork
            drive_frame(0, d, 0, 0, 1);
            begin
                repeat (78) @(posedge clk);
                #1 rx_ready_a = 1;
                @(posedge clk); #1 rx_ready_a = 0;
            end
        join
        cycles(2);
        chk("simultaneous push/pop no overrun", err_overrun_a, 0);
        chk("simultaneous push/pop pops", pops_a - p0, 1);
        rx_ready_a = 1;
        cycles(10);
        chk("overrun drain pop count", pops_a - p0, 5);
        chk("overrun drain scoreboard empty", exp_a.size(), 0);
        chk("overrun drain rx_valid", rx_valid_a, 0);

        // 8E1 loopback, back-to-back, no gap
        loop_b = 1;
        burst = '{8'h3C, 8'hFF, 8'h00};
        foreach (burst[i]) exp_b.push_back(burst[i]);
        tx_stream(1);
        cycles(4);
        chk("loopback scoreboard empty", exp_b.size(), 0);
        chk("loopback errors", {err_frame_b, err_parity_b, err_overrun_b}, 0);

        // Parity error: 0x01 with even parity bit 0
        loop_b = 0;
        drive_frame(1, 8'h01, 1, 0, 1);
        cycles(2);
        chk("parity error flag", err_parity_b, 1);
        chk("parity error no frame err", err_frame_b, 0);
        chk("parity error rx_valid", rx_valid_b, 0);
        // Bad parity and bad stop with err_clr in the completion cycle: set wins
        fork
            drive_frame(1, 8'h07, 1, 0, 0);
            begin
                repeat (86) @(posedge clk);
                #1 err_clr_b = 1;
                @(posedge clk); #1 err_clr_b = 0;
            end
        join
        cycles(2);
        chk("set beats clear frame", err_frame_b, 1);
        chk("set beats clear parity", err_parity_b, 1);
        chk("double error rx_valid", rx_valid_b, 0);
        err_clr_b = 1;
        @(negedge clk);
        chk("flags held during clr cycle", {err_frame_b, err_parity_b}, 2'b11);
        @(posedge clk); #1 err_clr_b = 0;
        @(negedge clk);
        chk("err_clr both flags", {err_frame_b, err_parity_b}, 0);
        @(posedge clk); #1;

        // Random loopback traffic on 8E1 and 7O2
        loop_b = 1;
        for (int k = 0; k < 1500; k++) begin
            tx_valid_b = ($urandom_range(0, 3) == 0);
            tx_data_b  = 8'($urandom);
            if (tx_valid_b && tx_ready_b) exp_b.push_back(tx_data_b);
            tx_valid_c = ($urandom_range(0, 3) == 0);
            tx_data_c  = 7'($urandom);
            if (tx_valid_c && tx_ready_c) exp_c.push_back(tx_data_c);
            rx_ready_b = ($urandom_range(0, 3) != 0);
            rx_ready_c = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        tx_valid_b = 0; tx_valid_c = 0; rx_ready_b = 1; rx_ready_c = 1;
        for (int k = 0; k < 3000 && (exp_b.size() != 0 || exp_c.size() != 0); k++)
            @(posedge clk);
        #1;
        chk("random b drained", exp_b.size(), 0);
        chk("random c drained", exp_c.size(), 0);
        chk("random b errors", {err_frame_b, err_parity_b, err_overrun_b}, 0);
        chk("random c errors", {err_frame_c, err_parity_c, err_overrun_c}, 0);
        loop_b = 0;
        cycles(30);

        // Reset during TX data bit 3 of 0xA0 (bit 3 is 0)
        tx_valid_a = 1; tx_data_a = 8'hA0;
        @(posedge clk); #1 tx_valid_a = 0;
        repeat (36) @(posedge clk);
        #3;
        chk("tx low in bit 3 before reset", uart_tx_a, 0);
        rst_n = 1'b0;
        #1;
        chk("reset mid-frame uart_tx", uart_tx_a, 1);
        chk("reset mid-frame tx_ready", tx_ready_a, 1);
        chk("reset mid-frame tx_busy", tx_busy_a, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cycles(2);
        burst = '{8'h55};
        tx_stream(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_fifo_transceiver.md
Name: uart_fifo_transceiver

Overview:
- Parametrised full-duplex UART transceiver that replaces the fixed 8N1 serial port behind the SoC's uart_rx/uart_tx pins.
- Adds configurable data width, parity, stop bits, baud divisor, TX/RX FIFOs with valid/ready handshakes, and sticky error reporting.
- Sits between the SoC bus peripheral logic and the chip pins.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..8.
- CLK_DIV, 434, clock cycles per bit; legal value is at least 4.
- PARITY_EN, 0, 1 = parity bit present.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- STOP_BITS, 1, stop bits transmitted, legal 1..2. RX checks only the first stop bit.
- FIFO_DEPTH, 4, entries per FIFO; must be a power of two, at least 2.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous active-low reset.
- tx_data, input, DATA_BITS: byte to transmit.
- tx_valid, input, 1: tx_data valid.
- tx_ready, output, 1: TX FIFO not full.
- rx_data, output, DATA_BITS: head of RX FIFO.
- rx_valid, output, 1: RX FIFO not empty.
- rx_ready, input, 1: consumer pops RX head.
- err_clr, input, 1: clears all sticky error flags.
- err_frame, output, 1: sticky, bad stop bit seen.
- err_parity, output, 1: sticky, parity mismatch seen.
- err_overrun, output, 1: sticky, RX byte dropped because the RX FIFO was full.
- tx_busy, output, 1: TX FIFO non-empty or TX shifter active.
- uart_rx, input, 1: serial input, asynchronous to clk.
- uart_tx, output, 1: serial output, idles high.

Behaviour:

Reset (asynchronous, rst_n low):
- uart_tx=1; tx_ready=1; rx_valid=0; rx_data=0; tx_busy=0; all error flags 0.
- Both FIFOs are emptied and both FSMs return to IDLE.
- Reset asserted mid-frame aborts the frame immediately; uart_tx returns high in the same cycle.

FIFOs:
- Push occurs on valid&ready; pop occurs on rx_valid&rx_ready.
- rx_data is the registered head entry.
- Simultaneous push and pop leaves the count unchanged. This holds even when the FIFO is full: the RX push is accepted because the pop frees the slot.
- Pointers wrap modulo FIFO_DEPTH.
- Full and empty are derived from a count of width log2(FIFO_DEPTH)+1.

TX FSM (states IDLE, START, DATA, PARITY, STOP):
- IDLE: when the TX FIFO is non-empty, pop one entry and enter START.
- Latency: a byte pushed at cycle N into an empty FIFO with an idle shifter drives uart_tx low at cycle N+2.
- Each bit is held exactly CLK_DIV cycles, timed by a down-counter reloaded on each bit.
- Data is sent LSB first over DATA_BITS bits.
- PARITY state is entered only when PARITY_EN=1. Parity is the XOR of the data bits, inverted when PARITY_ODD=1.
- STOP lasts STOP_BITS×CLK_DIV cycles.
- After STOP, go to START directly if the FIFO is non-empty (no idle gap); otherwise go to IDLE.

RX path:
- uart_rx passes through a 2-flop synchronizer reset to 1. All RX timing is measured from the synchronized signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a 1->0 transition of the synchronized input.
- START: wait CLK_DIV/2 cycles (integer division), then sample. If the sample is 1, it is a false start: return to IDLE and store nothing. If 0, enter DATA.
- DATA: sample at CLK_DIV intervals, shift in LSB first, DATA_BITS samples total.
- PARITY (only when PARITY_EN=1): one sample.
- STOP: one sample.

RX frame completion (the cycle the stop bit is sampled):
- Stop bit = 0: set err_frame; discard the byte.
- Parity mismatch: set err_parity; discard the byte.
- If both errors occur, both flags are set.
- Good frame with a pushable RX FIFO: push the byte.
- Good frame with the RX FIFO full and no pop that cycle: drop the byte and set err_overrun.
- The FSM returns to IDLE immediately after the stop sample, so a new start edge is accepted half a bit early.

Error flags:
- Sticky until err_clr.
- If a set event and err_clr coincide, the set wins.

tx_busy:
- Combinational: TX FIFO non-empty OR TX FSM not in IDLE.

Test Plan:
- Serial pattern: CLK_DIV=8, 8N1, push 0xA5 -> uart_tx carries 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles, start bit beginning at push+2; tx_busy falls after the 80th bit-cycle.
- Loopback, parity, back-to-back: uart_tx wired to uart_rx, PARITY_EN=1, PARITY_ODD=0, push 0x3C,0xFF,0x00 back-to-back -> rx_data pops 0x3C,0xFF,0x00 in order; parity bits sent are 0,0,0; no error flags; no idle gap between frames.
- Frame and parity errors with clear: drive a frame with stop bit 0 -> err_frame=1 and rx_valid stays 0. Drive data 0x01 with parity bit 0 (even parity) -> err_parity=1. Pulse err_clr -> both flags clear on the next cycle.
- Overrun: FIFO_DEPTH=4, rx_ready=0, receive 5 good bytes -> 4 bytes stored, the 5th dropped, err_overrun=1. Pop once in the same cycle as a 6th frame completes -> 6th byte accepted, count stays 4.
- False start: a 0-pulse of 2 cycles on uart_rx with CLK_DIV=8 -> no byte stored, no error flags, FSM back in IDLE; a following valid frame is received correctly.
- Reset mid-frame: assert rst_n low during TX bit 3 -> uart_tx=1 immediately, tx_ready=1, tx_busy=0. After release, push 0x55 -> a clean full frame is transmitted.
